// File: rtl/exception_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : exception_controller_if
//  Purpose  : Exception/interrupt request, vectoring and handshake bundle
//             between the system/core side (master) and exception_controller.
//  Revision : 1.0  initial release
// ============================================================================
interface exception_controller_if #(
    parameter int NUM_IRQ = 16
);
    logic [15:0]        exceptionRequest;
    logic [NUM_IRQ-1:0] interruptRequest;
    logic               interruptEnable;
    logic [15:0]        exceptionMask;
    logic [31:0]        isrBaseAddress;
    logic               instructionDone;
    logic               vectorAck;
    logic               exceptionReturn;
    logic               exceptionPending;
    logic [4:0]         cause;
    logic [31:0]        vectorAddress;
    logic               inService;

    modport master (
        output exceptionRequest, interruptRequest, interruptEnable, exceptionMask,
               isrBaseAddress, instructionDone, vectorAck, exceptionReturn,
        input  exceptionPending, cause, vectorAddress, inService
    );

    modport slave (
        input  exceptionRequest, interruptRequest, interruptEnable, exceptionMask,
               isrBaseAddress, instructionDone, vectorAck, exceptionReturn,
        output exceptionPending, cause, vectorAddress, inService
    );
endinterface
`default_nettype wire

// File: rtl/exception_controller.sv
`default_nettype none
// ============================================================================
//  Module   : exception_controller
//  Purpose  : Latches exception strobes, gates IRQs, selects the lowest cause
//             and hands the vector to the core; no nesting until return.
//             Define IRQ_SYNC_EN to add a 2-flop synchronizer on each IRQ.
//  Revision : 1.0  initial release
// ============================================================================
module exception_controller #(
    parameter int NUM_IRQ      = 16,
    parameter int VECTOR_SHIFT = 3
) (
    input  wire logic             clk,
    input  wire logic             reset,
    exception_controller_if.slave bus
);
    localparam int NUM_CAUSE = 16 + NUM_IRQ;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [15:0]          pend_exc_q, pend_exc_d;
    logic [4:0]           cause_q, cause_d;
    logic [31:0]          vector_q, vector_d;
    logic [NUM_IRQ-1:0]   irq;
    logic [NUM_CAUSE-1:0] eligible;
    logic [4:0]           sel_cause;
    logic                 take;
    logic                 ack_clr;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] irq_meta_q;
    logic [NUM_IRQ-1:0] irq_sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_meta_q <= '0;
            irq_sync_q <= '0;
        end else begin
            irq_meta_q <= bus.interruptRequest;
            irq_sync_q <= irq_meta_q;
        end
    end

    assign irq = irq_sync_q;
`else
    assign irq = bus.interruptRequest;
`endif

    assign eligible = {irq & {NUM_IRQ{bus.interruptEnable}},
                       pend_exc_q & bus.exceptionMask};

    // Scan downward so the lowest eligible cause is the last one written.
    always_comb begin
        sel_cause = '0;
        for (int i = NUM_CAUSE - 1; i >= 0; i--) begin
            if (eligible[i]) sel_cause = 5'(i);
        end
    end

    assign take    = (state_q == ST_IDLE) && (|eligible) && bus.instructionDone;
    assign ack_clr = (state_q == ST_PENDING) && bus.vectorAck;

    // A new strobe on the bit being acknowledged must survive the clear.
    always_comb begin
        pend_exc_d = pend_exc_q;
        if (ack_clr && !cause_q[4]) pend_exc_d[cause_q[3:0]] = 1'b0;
        pend_exc_d = pend_exc_d | bus.exceptionRequest;
    end

    assign cause_d  = take ? sel_cause : cause_q;
    assign vector_d = take ? (bus.isrBaseAddress + (32'(sel_cause) << VECTOR_SHIFT))
                           : vector_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_exc_q <= '0;
            cause_q    <= '0;
            vector_q   <= '0;
        end else begin
            pend_exc_q <= pend_exc_d;
            cause_q    <= cause_d;
            vector_q   <= vector_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (take)                state_d = ST_PENDING;
            ST_PENDING: if (bus.vectorAck)       state_d = ST_SERVICE;
            ST_SERVICE: if (bus.exceptionReturn) state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.exceptionPending = (state_q == ST_PENDING);
        bus.inService        = (state_q == ST_SERVICE);
        bus.cause            = cause_q;
        bus.vectorAddress    = vector_q;
    end
endmodule
`default_nettype wire
